// File: rtl/ascon_out_framer.sv
// Captures the Ascon core's byte-serial result streams and re-emits them as one
// header-prefixed valid/ready frame. Optional macro: ASCON_FRAMER_SQUASH_EN.
`default_nettype none

module ascon_out_framer #(
  parameter int Y    = 80,
  parameter int TAGW = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_ready_i,
  input  logic       dec_ready_i,
  input  logic       auth_i,
  input  logic [7:0] ct_byte_i,
  input  logic [7:0] tag_byte_i,
  input  logic [7:0] pt_byte_i,
  input  logic [7:0] dtag_byte_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam int YB    = Y / 8;
  localparam int TB    = TAGW / 8;
  localparam int N     = (YB > TB) ? YB : TB;
  localparam int FRAME = 1 + YB + TB;
  localparam int KW    = $clog2(N + 1);
  localparam int PW    = $clog2(FRAME);

  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  localparam logic [PW-1:0] PLAST = PW'(YB + TB - 1);
  localparam logic [5:0]    YB6   = 6'(YB);

`ifdef ASCON_FRAMER_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HDR     = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t                  state;
  logic                    enc_q;
  logic                    dec_q;
  logic                    mode;
  logic                    auth_r;
  logic [KW-1:0]           k;
  logic [PW-1:0]           pidx;
  // Payload bytes in emission order: data[0..YB-1] then tag[0..TB-1].
  logic [8*(YB+TB)-1:0]    pbuf;

  logic rise_e;
  logic rise_d;
  logic auth_now;

  assign rise_e   = enc_ready_i & ~enc_q;
  assign rise_d   = dec_ready_i & ~dec_q;
  // auth_r is only loaded at k=0, so bypass it on that edge.
  assign auth_now = (k == '0) ? (mode ? auth_i : 1'b1) : auth_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      enc_q     <= 1'b0;
      dec_q     <= 1'b0;
      mode      <= 1'b0;
      auth_r    <= 1'b0;
      k         <= '0;
      pidx      <= '0;
      m_data_o  <= 8'h00;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      enc_q     <= enc_ready_i;
      dec_q     <= dec_ready_i;
      overrun_o <= (state == IDLE) ? (rise_e & rise_d) : (rise_e | rise_d);
      case (state)
        IDLE: begin
          if (rise_e | rise_d) begin
            state  <= CAPTURE;
            mode   <= ~rise_e;
            k      <= '0;
            busy_o <= 1'b1;
          end
        end
        CAPTURE: begin
          if (int'(k) < YB)
            pbuf[8*int'(k) +: 8] <= mode ? pt_byte_i : ct_byte_i;
          if (int'(k) < TB)
            pbuf[8*(YB+int'(k)) +: 8] <= mode ? dtag_byte_i : tag_byte_i;
          if (k == '0)
            auth_r <= auth_now;
          if (k == KLAST) begin
            state     <= HDR;
            m_data_o  <= {mode, auth_now, YB6};
            m_valid_o <= 1'b1;
            m_last_o  <= SQUASH & mode & ~auth_now;
          end else begin
            k <= k + 1'b1;
          end
        end
        HDR: begin
          if (m_ready_i) begin
            if (SQUASH & mode & ~auth_r) begin
              state     <= IDLE;
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              busy_o    <= 1'b0;
            end else begin
              state    <= PAYLOAD;
              pidx     <= '0;
              m_data_o <= pbuf[7:0];
              m_last_o <= (PLAST == '0);
            end
          end
        end
        PAYLOAD: begin
          if (m_ready_i) begin
            if (pidx == PLAST) begin
              state     <= IDLE;
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              busy_o    <= 1'b0;
            end else begin
              pidx     <= pidx + 1'b1;
              m_data_o <= pbuf[8*(int'(pidx)+1) +: 8];
              m_last_o <= ((pidx + 1'b1) == PLAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ascon_out_framer.sv
// Directed bench for ascon_out_framer (Y=80, TAGW=128); honours ASCON_FRAMER_SQUASH_EN.
`default_nettype none

module tb_ascon_out_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_ready, dec_ready, auth;
  logic [7:0] ct_b, tag_b, pt_b, dtag_b;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready;
  logic       busy, overrun;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ascon_out_framer #(.Y(80), .TAGW(128)) dut (
    .clk(clk), .rst(rst),
    .enc_ready_i(enc_ready), .dec_ready_i(dec_ready), .auth_i(auth),
    .ct_byte_i(ct_b), .tag_byte_i(tag_b), .pt_byte_i(pt_b), .dtag_byte_i(dtag_b),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
    .busy_o(busy), .overrun_o(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Trigger must already be driven; plays the core's byte stream for 16 cycles.
  task automatic feed(input bit dec, input bit a, input logic [7:0] dbase,
                      input logic [7:0] tbase, input bit ov_exp, input bit hold);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      ct_b   = dec ? 8'h55 : ((k < 10) ? 8'(dbase + k) : 8'hEE);
      tag_b  = dec ? 8'h55 : 8'(tbase + k);
      pt_b   = dec ? ((k < 10) ? 8'(dbase + k) : 8'hEE) : 8'h66;
      dtag_b = dec ? 8'(tbase + k) : 8'h66;
      auth   = a;
      if (k == 0) begin
        chk("overrun_trig", overrun, ov_exp);
        chk("busy_capture", busy, 1);
      end
      if (k == 1) chk("overrun_clear", overrun, 0);
    end
    chk("hdr_early", m_valid, 0);
    if (!hold) begin
      enc_ready = 1'b0;
      dec_ready = 1'b0;
    end
    @(posedge clk); #1;
    chk("hdr_latency", m_valid, 1);
  endtask

  task automatic collect(input logic [7:0] hdr, input logic [7:0] dbase,
                         input logic [7:0] tbase, input int nexp,
                         input bit toggle, input bit poke);
    logic [7:0] got[$];
    bit         lastf[$];
    int         cyc = 0;
    logic [7:0] hd = 8'h00;
    logic       hl = 1'b0;
    bit         stalled = 1'b0;
    bit         done = 1'b0;
    logic [7:0] e;
    while (!done && cyc < 200) begin
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hd);
        chk("stall_last", m_last, hl);
      end
      if (poke) begin
        if (cyc == 3) enc_ready = 1'b0;
        if (cyc == 5) enc_ready = 1'b1;
        if (cyc == 6) chk("overrun_busy", overrun, 1);
        if (cyc == 7) chk("overrun_busy_clear", overrun, 0);
      end
      stalled = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lastf.push_back(m_last);
        if (m_last) done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    chk("frame_done", done, 1);
    chk("frame_len", got.size(), nexp);
    for (int i = 0; i < got.size() && i < nexp; i++) begin
      if (i == 0)       e = hdr;
      else if (i <= 10) e = 8'(dbase + i - 1);
      else              e = 8'(tbase + i - 11);
      chk($sformatf("byte%0d", i), got[i], e);
      chk($sformatf("last%0d", i), lastf[i], (i == nexp - 1));
    end
    chk("busy_after", busy, 0);
    chk("valid_after", m_valid, 0);
    if (!toggle) chk("frame_cycles", cyc, nexp);
  endtask

  initial begin
    rst = 1'b1; enc_ready = 1'b0; dec_ready = 1'b0; auth = 1'b0; m_ready = 1'b0;
    ct_b = 8'h00; tag_b = 8'h00; pt_b = 8'h00; dtag_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Encrypt; level held high through the frame must not retrigger.
    enc_ready = 1'b1;
    feed(0, 0, 8'h00, 8'hA0, 0, 1);
    collect(8'h4A, 8'h00, 8'hA0, 27, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_retrigger", busy, 0);
    enc_ready = 1'b0;
    @(posedge clk); #1;

    // Decrypt, authenticated.
    dec_ready = 1'b1;
    feed(1, 1, 8'h10, 8'hB0, 0, 0);
    collect(8'hCA, 8'h10, 8'hB0, 27, 0, 0);

    // Decrypt, authentication failure.
    dec_ready = 1'b1;
    feed(1, 0, 8'h20, 8'hC0, 0, 0);
`ifdef ASCON_FRAMER_SQUASH_EN
    collect(8'h8A, 8'h20, 8'hC0, 1, 0, 0);
`else
    collect(8'h8A, 8'h20, 8'hC0, 27, 0, 0);
`endif

    // Backpressure: ready alternates 1010...
    enc_ready = 1'b1;
    feed(0, 1, 8'h30, 8'hD0, 0, 0);
    collect(8'h4A, 8'h30, 8'hD0, 27, 1, 0);

    // Simultaneous rise, then a second enc rise mid-payload.
    enc_ready = 1'b1;
    dec_ready = 1'b1;
    feed(0, 0, 8'h40, 8'hE0, 1, 0);
    collect(8'h4A, 8'h40, 8'hE0, 27, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("poke_no_retrigger", busy, 0);
    enc_ready = 1'b0;
    @(posedge clk); #1;

    // Reset mid-payload, then a clean frame.
    enc_ready = 1'b1;
    feed(0, 0, 8'h50, 8'hF0, 0, 0);
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    enc_ready = 1'b1;
    feed(0, 0, 8'h60, 8'h70, 0, 0);
    collect(8'h4A, 8'h60, 8'h70, 27, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ascon_out_framer.md
Name: ascon_out_framer

Overview:
Downstream stage of the Ascon encrypt/decrypt core. It consumes the core's byte-serial result streams (ciphertext + tag after encryption, plaintext + tag after decryption) and captures them into a local buffer. It then emits one framed byte stream with a header over a valid/ready interface to the host-side transport. This decouples the host from the core, whose output bytes advance every cycle with no backpressure.

Parameters:
Y, 80, plaintext/ciphertext length in bits; multiple of 8, Y/8 <= 63
TAGW, 128, tag length in bits; multiple of 8
(derived) YB = Y/8, TB = TAGW/8, N = max(YB,TB), FRAME = 1+YB+TB

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enc_ready_i  in  1  core encryption-ready level
dec_ready_i  in  1  core decryption-ready level
auth_i  in  1  core message-authentication flag
ct_byte_i  in  8  ciphertext byte stream, byte k = bits [8k+7:8k]
tag_byte_i  in  8  encryption tag byte stream
pt_byte_i  in  8  decrypted plaintext byte stream
dtag_byte_i  in  8  decryption tag byte stream
m_data_o  out  8  framed output byte
m_valid_o  out  1  output byte valid
m_last_o  out  1  final byte of frame
m_ready_i  in  1  downstream ready
busy_o  out  1  high whenever state != IDLE
overrun_o  out  1  one-cycle pulse: trigger ignored

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. All outputs 0; state IDLE; edge registers enc_q/dec_q cleared; buffer contents don't-care. A reset mid-frame aborts the frame immediately. m_valid_o is low the cycle after.
- Trigger: rise_e = enc_ready_i & ~enc_q; rise_d = dec_ready_i & ~dec_q. enc_q and dec_q are updated every cycle.
- IDLE: on rise_e go to CAPTURE with mode=0. On rise_d go to CAPTURE with mode=1.
  - Simultaneous rise_e and rise_d: encryption wins and overrun_o pulses.
  - A level that stays high never retriggers.
- CAPTURE: the core registers byte 0 on the same edge the trigger is sampled. On each of the next N edges, byte index k (0..N-1) is stored:
  - mode=0: ct[k] from ct_byte_i if k<YB; tag[k] from tag_byte_i if k<TB.
  - mode=1: pt_byte_i and dtag_byte_i are stored instead.
  - auth_i is sampled at k=0 and held in auth_r. For mode=0, auth_r is forced to 1.
  - After k=N-1, go to HDR.
- HDR: m_data_o = {mode, auth_r, YB[5:0]}, m_valid_o=1. Advance to PAYLOAD when m_ready_i is high.
- PAYLOAD: emit data[0..YB-1] then tag[0..TB-1], one byte per accepted handshake. m_last_o=1 only with tag[TB-1]. On the final accept go to IDLE.
- Handshake: a transfer happens when m_valid_o & m_ready_i. While m_valid_o is high and m_ready_i is low, m_data_o and m_last_o hold stable. m_valid_o never drops before its transfer.
- Minimum latency: trigger edge -> header valid = N+1 cycles. With m_ready_i tied high, the frame takes FRAME consecutive cycles.
- Triggers in CAPTURE, HDR or PAYLOAD: ignored, and overrun_o pulses for one cycle. enc_q and dec_q still track, so a level held high is not seen again later.
- Counters: byte index is ceil(log2(N+1)) bits and saturates at its terminal count; no wrap-around.

Optional Feature:
ASCON_FRAMER_SQUASH_EN
- Defined: if mode=1 and auth_r=0, the payload is suppressed. The frame is the header only (8'h8A for Y=80) with m_last_o=1, then the block returns to IDLE. Captured bytes are discarded.
- Not defined: the full frame is always emitted. On an authentication failure it carries the core's substitute random bytes, and header bit 6 = 0.

Test Plan:
- Encrypt, Y=80/TAGW=128, ct bytes 0x00..0x09, tag bytes 0xA0..0xAF, m_ready_i=1 -> header 0x4A then 00..09, A0..AF. Frame is 27 bytes; m_last_o only on 0xAF; header appears 17 cycles after trigger.
- Decrypt, auth_i=1, pt 0x10..0x19, dtag 0xB0..0xBF -> header 0xCA, then pt bytes, then dtag bytes; 27 bytes.
- Decrypt, auth_i=0 -> header 0x8A; full 27-byte frame without the macro, single header byte with last=1 with the macro.
- Backpressure: m_ready_i toggles 1010... during PAYLOAD -> each byte held stable across stalls, order intact, total 27 transfers.
- enc_ready_i and dec_ready_i rise in the same cycle -> encryption frame (0x4A) and overrun_o pulses once. A second enc rise during PAYLOAD -> another overrun_o pulse and the frame is unaffected.
- rst asserted at PAYLOAD byte 5 -> m_valid_o=0 the next cycle, busy_o=0. A new trigger then yields a clean 27-byte frame.
